// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU control codes, mult/div op codes and MDU state encoding
package mips_pkg;

  localparam int DW = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - execute-stage bus between decode/writeback and alu_exec
interface alu_exec_if;
  import mips_pkg::*;

  logic [3:0]    ALUCtrl;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [4:0]    shamt;
  logic [DW-1:0] alu_result;
  logic          zero;
  logic          md_start;
  logic [1:0]    md_op;
  logic [1:0]    hilo_we;
  logic          md_read;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic          md_busy;
  logic          md_done;
  logic          stall;

  modport master (
    output ALUCtrl, src_a, src_b, shamt, md_start, md_op, hilo_we, md_read,
    input  alu_result, zero, hi, lo, md_busy, md_done, stall
  );

  modport slave (
    input  ALUCtrl, src_a, src_b, shamt, md_start, md_op, hilo_we, md_read,
    output alu_result, zero, hi, lo, md_busy, md_done, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - 32-iteration shift-add multiplier / restoring divider with HI/LO
module muldiv_seq import mips_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1:0]    hilo_we,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          busy,
  output logic          done
);

  md_state_t       state, state_nxt;
  logic [5:0]      cnt;
  logic [2*DW-1:0] acc, acc_nxt, prod;
  logic [DW-1:0]   b_mag, a_orig, quo, rem;
  logic [DW-1:0]   a_mag_in, b_mag_in;
  logic            is_div, sign_q, sign_r, div_zero;
  logic            a_neg, b_neg, launch, last;
  logic [DW:0]     psum, trial, tdiff;

  assign a_neg    = op[0] & src_a[DW-1];
  assign b_neg    = op[0] & src_b[DW-1];
  assign a_mag_in = a_neg ? -src_a : src_a;
  assign b_mag_in = b_neg ? -src_b : src_b;
  assign busy     = (state == MD_RUN);
  assign launch   = (state == MD_IDLE) && start;
  assign last     = (state == MD_RUN) && (cnt == 6'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_RUN;
      MD_RUN:  if (cnt == 6'd31) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // acc holds {upper product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    psum    = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, b_mag} : {(DW+1){1'b0}});
    trial   = {acc[2*DW-1:DW], acc[DW-1]};
    tdiff   = trial - {1'b0, b_mag};
    acc_nxt = {psum, acc[DW-1:1]};
    if (is_div) begin
      if (trial >= {1'b0, b_mag}) acc_nxt = {tdiff[DW-1:0], acc[DW-2:0], 1'b1};
      else                        acc_nxt = {trial[DW-1:0], acc[DW-2:0], 1'b0};
    end
    prod = sign_q ? -acc_nxt : acc_nxt;
    quo  = sign_q ? -acc_nxt[DW-1:0] : acc_nxt[DW-1:0];
    rem  = sign_r ? -acc_nxt[2*DW-1:DW] : acc_nxt[2*DW-1:DW];
    if (div_zero) begin
      quo = {DW{1'b1}};
      rem = a_orig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      b_mag    <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (launch) begin
        acc      <= {{DW{1'b0}}, a_mag_in};
        b_mag    <= b_mag_in;
        a_orig   <= src_a;
        is_div   <= op[1];
        sign_q   <= a_neg ^ b_neg;
        sign_r   <= a_neg;
        div_zero <= op[1] && (src_b == '0);
        cnt      <= '0;
      end else if (busy) begin
        acc <= acc_nxt;
        cnt <= last ? 6'd0 : cnt + 6'd1;
      end
      // Direct HI/LO writes only land while idle; a launch in the same cycle is later overwritten
      if (last) begin
        if (is_div) {hi, lo} <= {rem, quo};
        else        {hi, lo} <= prod;
      end else if (!busy) begin
        if (hilo_we[1]) hi <= src_a;
        if (hilo_we[0]) lo <= src_a;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - combinational ALU, zero flag and stall for the MIPS execute stage
module alu_exec import mips_pkg::*; (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  logic [DW-1:0] result;
  logic          slt;
  logic          alu_ctrl_unused;

  assign alu_ctrl_unused = bus.ALUCtrl[3];
  assign slt = $signed(bus.src_a) < $signed(bus.src_b);

  always_comb begin
    result = '0;
    case (bus.ALUCtrl[2:0])
      ALU_ADD: result = bus.src_a + bus.src_b;
      ALU_SUB: result = bus.src_a - bus.src_b;
      ALU_AND: result = bus.src_a & bus.src_b;
      ALU_OR:  result = bus.src_a | bus.src_b;
      ALU_SLT: result = {{(DW-1){1'b0}}, slt};
      ALU_SLL: result = bus.src_b << bus.shamt;
      ALU_SRL: result = bus.src_b >> bus.shamt;
      default: result = '0;
    endcase
  end

  assign bus.alu_result = result;
  assign bus.zero       = (result == '0);
  assign bus.stall      = bus.md_busy & (bus.md_read | bus.md_start | (|bus.hilo_we));

  muldiv_seq u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.md_start),
    .op      (bus.md_op),
    .hilo_we (bus.hilo_we),
    .src_a   (bus.src_a),
    .src_b   (bus.src_b),
    .hi      (bus.hi),
    .lo      (bus.lo),
    .busy    (bus.md_busy),
    .done    (bus.md_done)
  );

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the single-cycle MIPS datapath, directly downstream of the ALU control decoder. Consumes the 4-bit `ALUCtrl` code and the two operands, and produces the combinational ALU result and zero flag for writeback and branch. Also owns an iterative 32-cycle multiply/divide unit with HI/LO registers. The unit raises `stall` so the PC/writeback logic holds the instruction when it depends on an unfinished operation.

## Interface
- `DW`, 32: datapath width. Fixed at 32; the iteration count equals `DW`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ALUCtrl` in 4: operation code from ALU control. Only `[2:0]` is decoded.
- `src_a` in 32: rs operand.
- `src_b` in 32: rt operand, or the immediate.
- `shamt` in 5: shift amount.
- `alu_result` out 32: combinational result.
- `zero` out 1: high when `alu_result == 0`.
- `md_start` in 1: launch a mult/div on `src_a`/`src_b`.
- `md_op` in 2: `[1]` 0 = mult, 1 = div. `[0]` 1 = signed.
- `hilo_we` in 2: `[1]` mthi, `[0]` mtlo. Write data is `src_a`.
- `md_read` in 1: the current instruction is mfhi/mflo.
- `hi`, `lo` out 32 each: registered HI/LO.
- `md_busy` out 1: an iteration is in progress.
- `md_done` out 1: one-cycle pulse after HI/LO are committed.
- `stall` out 1: hold the current instruction.

## Operation
- ALU decode of `ALUCtrl[2:0]`:
  - 010: `src_a + src_b` (wrap, no overflow trap).
  - 110: `src_a - src_b`.
  - 000: AND.
  - 001: OR.
  - 111: signed slt, giving 32'd1 or 32'd0.
  - 100: `src_b << shamt`.
  - 101: `src_b >> shamt` (logical).
  - 011: 0.
- `ALUCtrl[3]` is ignored; it carries garbage for load/store and branch.
- MDU FSM states are IDLE and RUN.
- IDLE → RUN when `md_start` is high and `md_busy` is low.
  - Latch the operand magnitudes (absolute values when signed).
  - Latch the result signs: quotient/product sign = `sa ^ sb`; remainder sign = `sa`.
  - Clear the 6-bit counter.
- RUN does one iteration per cycle.
  - Mult: shift-add.
  - Div: restoring.
- RUN → IDLE when the counter reaches 31.
  - On that edge, commit the sign-corrected results: mult writes `{HI,LO}` = 64-bit product; div writes LO = quotient, HI = remainder.
  - Assert `md_done` for the next cycle.
- Divide by zero still takes 32 cycles. Result: LO = 32'hFFFF_FFFF, HI = the original `src_a`.
- Signed -2^31 / -1 gives LO = 32'h8000_0000, HI = 0.
- `md_start` while busy is ignored.
- `hilo_we` while idle writes HI and/or LO on the next edge.
- `hilo_we` while busy is dropped and stalls instead.
- If `md_start` and `hilo_we` arrive in the same idle cycle, both take effect. The MDU commit later overwrites the write.
- `stall = md_busy & (md_read | md_start | |hilo_we)`.

## Timing
- ALU path: zero latency, purely combinational.
- `md_start` is sampled at edge E0.
- `md_busy` is high for exactly 32 cycles, E0 through E32.
- HI/LO update at E32.
- `md_done` is high in the cycle after E32, and `md_busy` is low in that same cycle.
- A new `md_start` in the `md_done` cycle is accepted: back-to-back issue with no bubble.
- `md_read` in the `md_done` cycle sees the new HI/LO and does not stall.
- Reset values: `hi` = `lo` = 0, `md_busy` = `md_done` = `stall` = 0, FSM in IDLE, counter 0.
- Reset asserted mid-operation aborts the operation. No commit occurs and no `md_done` pulse is produced.

## Structure
- Shared package `mips_pkg`:
  - `ALUCtrl` localparams: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`, `ALU_SLL`, `ALU_SRL`.
  - `md_op` codes: `MD_MULTU` = 00, `MD_MULT` = 01, `MD_DIVU` = 10, `MD_DIV` = 11.
  - MDU state encoding.
- Sub-module `muldiv_seq` contains:
  - the FSM, counter and iteration datapath;
  - the HI/LO registers;
  - the done/busy logic.
- `alu_exec` keeps the combinational ALU and the `stall` equation.

## Test plan
- `ALUCtrl` = 1010, a = 32'h7FFF_FFFF, b = 1 → `alu_result` = 32'h8000_0000, `zero` = 0. `ALUCtrl` = 0110, a = b = 5 → `zero` = 1.
- slt with a = 32'hFFFF_FFFF, b = 1 → result 1. sll with b = 1, shamt = 31 → 32'h8000_0000. srl with b = 32'h8000_0000, shamt = 31 → 1.
- mult a = -3, b = 5 → `md_busy` high for 32 cycles, `md_done` in cycle 33, HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFF1. multu with a = b = 32'hFFFF_FFFF → HI = 32'hFFFF_FFFE, LO = 1.
- div a = 7, b = -2 → LO = 32'hFFFF_FFFD, HI = 1. divu a = 9, b = 0 → LO = 32'hFFFF_FFFF, HI = 9. div a = 32'h8000_0000, b = -1 → LO = 32'h8000_0000, HI = 0.
- `md_read` at cycle 10 of a div → `stall` = 1 until the `md_done` cycle. `hilo_we` = 01 while busy → LO keeps the MDU result. `md_start` in the `md_done` cycle → a second operation starts immediately.
- `rst` pulsed at cycle 15 of a mult → HI = LO = 0 and `md_busy` = 0 asynchronously, with no `md_done` pulse.
